// File: rtl/div_pkg.sv
// div_pkg: types and constants shared by the divider request scheduler.
//
// Contents:
//   DIV_WIDTH / DIV_FBITS / DIV_TAG_W : widths the request struct is built from
//   MAX_POS / MIN_NEG                 : saturation values derived from DIV_WIDTH
//   sched_state_e                     : scheduler FSM states
//   div_req_t                         : one queued request {a, b, tag}
//
// FIXED_POINT_BITS sets the fractional bit count; it defaults to 4 when the
// build does not define it.

`ifndef FIXED_POINT_BITS
`define FIXED_POINT_BITS 4
`endif

package div_pkg;

  localparam int DIV_WIDTH = 12;
  localparam int DIV_FBITS = `FIXED_POINT_BITS;
  localparam int DIV_TAG_W = 4;

  localparam logic [DIV_WIDTH-1:0] MAX_POS = {1'b0, {(DIV_WIDTH-1){1'b1}}};
  localparam logic [DIV_WIDTH-1:0] MIN_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] a;
    logic [DIV_WIDTH-1:0] b;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

endpackage

// File: rtl/div_req_fifo.sv
// div_req_fifo: synchronous FIFO of div_req_t entries.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (pointers clear)
//   push_i        : write push_data_i when not full
//   push_data_i   : request to enqueue
//   pop_i         : drop the head entry when not empty
//   pop_data_o    : current head entry (valid while !empty_o)
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//
// A push into a full FIFO is dropped even when a pop happens in the same
// cycle; there is no pass-through path.

module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  div_req_t push_data_i,
  input  logic     pop_i,
  output div_req_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  div_req_t    mem_q [DEPTH];

  always_comb begin
    full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_o    = (wr_ptr_q == rd_ptr_q);
    do_push    = push_i && !full_o;
    do_pop     = pop_i && !empty_o;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: queues tagged divide requests and runs them one at a time
// on the shared iterative divider, returning tagged results in request order.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : request stream; in_a, in_b (signed), in_tag
//   out_valid/out_ready        : result stream; out_val (signed), out_tag,
//                                out_dbz, out_ovf
//   idle                       : FIFO empty, FSM idle, no result pending
//   div_start, div_a, div_b    : issue side of the divider
//   div_busy, div_done, div_dbz, div_ovf, div_val : divider status/result
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The sender holds valid and its payload until that edge; out_* stay stable
// while out_valid && !out_ready.
//
// Build option DIV_SAT_EN: error results (dbz/ovf) return a saturated value
// chosen from operand signs captured at pop time; otherwise they return 0.

module div_scheduler
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int FBITS = DIV_FBITS,
  parameter int DEPTH = 4,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             idle,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_dbz,
  input  logic             div_ovf,
  input  logic [WIDTH-1:0] div_val
);

  // The queued request struct is sized from the package constants.
  if (WIDTH != DIV_WIDTH || TAG_W != DIV_TAG_W || FBITS != DIV_FBITS) begin : g_cfg_mismatch
    $error("div_scheduler parameters must match div_pkg widths");
  end

  sched_state_e     state_q, state_d;
  div_req_t         push_req, head_req;
  logic             fifo_full, fifo_empty, push, can_issue;
  logic [WIDTH-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] out_val_q, out_val_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_valid_q, out_valid_d;
  logic             out_dbz_q, out_dbz_d, out_ovf_q, out_ovf_d;
  logic [WIDTH-1:0] err_val;
`ifdef DIV_SAT_EN
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
`endif

  assign push_req = '{a: in_a, b: in_b, tag: in_tag};
  assign push     = in_valid && in_ready;
  // Wait for the divider to drain (e.g. after a reset mid-operation) and for
  // the previous result to be taken before issuing the next one.
  assign can_issue = (state_q == S_IDLE) && !fifo_empty && !div_busy && !out_valid_q;

  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (can_issue),
    .pop_data_o  (head_req),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state. div_done outside S_WAIT is a leftover and is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (can_issue) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (div_done) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    in_ready  = rst_n && !fifo_full;
    div_start = (state_q == S_ISSUE);
    idle      = fifo_empty && (state_q == S_IDLE) && !out_valid_q;
  end

  // Value returned in place of the quotient on dbz/ovf.
  always_comb begin
`ifdef DIV_SAT_EN
    if (div_dbz) err_val = sign_a_q ? MIN_NEG : MAX_POS;
    else         err_val = (sign_a_q ^ sign_b_q) ? MIN_NEG : MAX_POS;
`else
    err_val = '0;
`endif
  end

  always_comb begin
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    tag_d       = tag_q;
    out_val_d   = out_val_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    out_dbz_d   = out_dbz_q;
    out_ovf_d   = out_ovf_q;
`ifdef DIV_SAT_EN
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
`endif
    if (can_issue) begin
      div_a_d  = head_req.a;
      div_b_d  = head_req.b;
      tag_d    = head_req.tag;
`ifdef DIV_SAT_EN
      sign_a_d = head_req.a[WIDTH-1];
      sign_b_d = head_req.b[WIDTH-1];
`endif
    end
    if (state_q == S_WAIT && div_done) begin
      out_val_d   = (div_dbz || div_ovf) ? err_val : div_val;
      out_dbz_d   = div_dbz;
      out_ovf_d   = div_ovf;
      out_tag_d   = tag_q;
      out_valid_d = 1'b1;
    end
    if (state_q == S_OUT && out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a_q     <= '0;
      div_b_q     <= '0;
      tag_q       <= '0;
      out_val_q   <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_dbz_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
`ifdef DIV_SAT_EN
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
`endif
    end else begin
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      tag_q       <= tag_d;
      out_val_q   <= out_val_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      out_dbz_q   <= out_dbz_d;
      out_ovf_q   <= out_ovf_d;
`ifdef DIV_SAT_EN
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
`endif
    end
  end

  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign out_val   = out_val_q;
  assign out_tag   = out_tag_q;
  assign out_valid = out_valid_q;
  assign out_dbz   = out_dbz_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: bench for div_scheduler with a behavioural divider, a
// result scoreboard and directed plus random request traffic.
// Honours DIV_SAT_EN the same way the design does.

module tb_div_scheduler;

  localparam int W        = 12;
  localparam int TW       = 4;
  localparam int FB       = 4;
  localparam int LAT_NORM = W - 1 + FB + 4;
  localparam int RW       = W + TW + 2;

`ifdef DIV_SAT_EN
  localparam logic [W-1:0] SAT_POS = 12'h7FF;
`else
  localparam logic [W-1:0] SAT_POS = 12'h000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_val;
  logic [TW-1:0] out_tag;
  logic          out_dbz, out_ovf, idle;
  logic          div_start;
  logic [W-1:0]  div_a, div_b;
  logic          div_busy = 1'b0;
  logic          div_done = 1'b0;
  logic          div_dbz  = 1'b0;
  logic          div_ovf  = 1'b0;
  logic [W-1:0]  div_val  = '0;

  div_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_tag   (out_tag),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf),
    .idle      (idle),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_dbz   (div_dbz),
    .div_ovf   (div_ovf),
    .div_val   (div_val)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Fixed-point signed divide: quotient = (a * 2^FB) / b, truncated.
  function automatic void div_math(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic dz, output logic ov);
    int sa, sb;
    longint qi;
    logic [63:0] qb;
    sa = $signed(a);
    sb = $signed(b);
    dz = (sb == 0);
    ov = 1'b0;
    q  = '0;
    if (!dz) begin
      qi = (longint'(sa) * 16) / longint'(sb);
      ov = (qi > 2047) || (qi < -2048);
      qb = qi;
      q  = qb[W-1:0];
    end
  endfunction

  // Expected result record {val, tag, dbz, ovf} for one request.
  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [TW-1:0] tag);
    logic [W-1:0] q;
    logic dz, ov;
    div_math(a, b, q, dz, ov);
    if (dz || ov) begin
`ifdef DIV_SAT_EN
      if (dz) q = a[W-1] ? 12'h800 : 12'h7FF;
      else    q = (a[W-1] ^ b[W-1]) ? 12'h800 : 12'h7FF;
`else
      q = '0;
`endif
    end
    return {q, tag, dz, ov};
  endfunction

  // ---------------- behavioural divider ----------------
  int           div_cnt = 0;
  logic [W-1:0] nxt_val;
  logic         nxt_dbz, nxt_ovf;

  always @(negedge clk) begin
    div_done = 1'b0;
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_done = 1'b1;
        div_busy = 1'b0;
        div_val  = nxt_val;
        div_dbz  = nxt_dbz;
        div_ovf  = nxt_ovf;
      end
    end else if (div_start) begin
      div_math(div_a, div_b, nxt_val, nxt_dbz, nxt_ovf);
      if (nxt_dbz || nxt_ovf) begin
        nxt_val = W'($urandom);
        div_cnt = 1;
      end else begin
        div_cnt = LAT_NORM;
      end
      div_busy = 1'b1;
    end
  end

  // ---------------- out_ready driver ----------------
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  always @(posedge clk) begin
    #1;
    out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] e;
  logic [RW-1:0] held;
  logic [RW-1:0] last_res = '0;
  logic          hold_prev = 1'b0;
  int            n_out = 0;

  always @(negedge clk) begin
    if (rst_n && hold_prev)
      check_eq("out_stable", {out_valid, out_val, out_tag, out_dbz, out_ovf}, {1'b1, held});
    hold_prev = rst_n && out_valid && !out_ready;
    held      = {out_val, out_tag, out_dbz, out_ovf};
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_tag));
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_val", out_val, e[RW-1 -: W]);
        check_eq("out_tag", out_tag, e[TW+1 -: TW]);
        check_eq("out_flags", {out_dbz, out_ovf}, e[1:0]);
      end
      last_res = {out_val, out_tag, out_dbz, out_ovf};
      n_out++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                      input int budget, output bit acc);
    int n;
    n        = 0;
    acc      = 1'b0;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_valid = 1'b1;
    while (!acc && n < budget) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !idle) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({name, "_drain"}, 32'((exp_q.size() == 0) && idle), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_b();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return W'($urandom_range(1, 3));
    return W'($urandom_range(1, 4095));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int n, n_acc;
    bit saw_done, started, after_checked;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_tag   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_idle", idle, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_outs", {out_val, out_tag, out_dbz, out_ovf}, 0);
    check_eq("rst_div", {div_start, div_a, div_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Positive divide, issue latency from acceptance.
    send(12'h030, 12'h020, 4'd5, 10, acc);
    check_eq("t1_acc", acc, 1);
    n = 0;
    while (!div_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("t1_start_lat", n, 2);
    check_eq("t1_div_ops", {div_a, div_b}, {12'h030, 12'h020});
    @(posedge clk); #1;
    wait_drain("t1", 100);
    check_eq("t1_res", last_res, {12'h018, 4'd5, 2'b00});

    // Negative dividend.
    send(12'hFD0, 12'h020, 4'd1, 10, acc);
    wait_drain("t2", 100);
    check_eq("t2_res", last_res, {12'hFE8, 4'd1, 2'b00});

    // Divide by zero.
    send(12'h030, 12'h000, 4'd2, 10, acc);
    wait_drain("t3", 100);
    check_eq("t3_res", last_res, {SAT_POS, 4'd2, 2'b10});

    // Overflow.
    send(12'h7F0, 12'h001, 4'd3, 10, acc);
    wait_drain("t4", 100);
    check_eq("t4_res", last_res, {SAT_POS, 4'd3, 2'b01});

    // Back-pressure: DEPTH+1 requests absorbed, then in order on release.
    ready_mode = 0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(W'($urandom), W'($urandom_range(1, 4095)), TW'(i), 40, acc);
      if (acc) n_acc++;
    end
    check_eq("bp_acc", n_acc, 5);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    ready_mode = 1;
    n_acc = 0;
    for (int i = 5; i < 8; i++) begin
      send(W'($urandom), W'($urandom_range(1, 4095)), TW'(i), 300, acc);
      if (acc) n_acc++;
    end
    check_eq("bp_rest_acc", n_acc, 3);
    wait_drain("bp", 600);

    // Random traffic with random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      send(W'($urandom), rand_b(), TW'($urandom), 400, acc);
      check_eq("rnd_acc", acc, 1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    wait_drain("rnd", 2000);

    // Reset while the divider is mid-operation.
    ready_mode = 1;
    send(12'h030, 12'h020, 4'd9, 10, acc);
    n = 0;
    while (!div_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("rm_started", div_start, 1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rm_in_ready", in_ready, 0);
    check_eq("rm_idle", idle, 1);
    check_eq("rm_outs", {out_valid, out_val, out_tag, out_dbz, out_ovf}, 0);
    check_eq("rm_div", {div_start, div_a, div_b}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(12'h060, 12'h020, 4'hA, 5, acc);
    check_eq("rm_acc", acc, 1);
    saw_done = 1'b0;
    started = 1'b0;
    after_checked = 1'b0;
    n = 0;
    while (!started && n < 80) begin
      @(negedge clk); #1;
      n++;
      if (saw_done && !after_checked) begin
        check_eq("rm_stray_ignored", out_valid, 0);
        after_checked = 1'b1;
      end
      if (div_start) started = 1'b1;
      else if (div_done) saw_done = 1'b1;
    end
    check_eq("rm_issue", started, 1);
    check_eq("rm_issue_after_drain", saw_done, 1);
    @(posedge clk); #1;
    wait_drain("rm", 200);
    check_eq("rm_res", last_res, {12'h030, 4'hA, 2'b00});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
